// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Stage tags carry just enough of each in-flight instruction to detect
// RAW hazards: its destination register and whether it writes / is a load.
package pipe_pkg;

  // Widest register address a tag can hold; narrower addresses are zero-extended.
  localparam int REG_ADDR_W_MAX = 8;

  // Forward-select value meaning "take the operand from the register file".
  localparam int FWD_REGFILE = 0;

  // Tracked-stage index of write-back (1=EX, 2=MEM, 3=WB).
  localparam int WB_STAGE = 3;

  // Instruction word the datapath inserts for a bubble or flush.
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef logic [REG_ADDR_W_MAX-1:0] tag_reg_t;

  typedef struct packed {
    logic     valid;
    tag_reg_t dst;
    logic     reg_write;
    logic     mem_read;
  } stage_tag_t;

  localparam stage_tag_t TAG_INVALID = '0;

  // Build the tag of a real instruction entering EX.
  function automatic stage_tag_t make_tag(input tag_reg_t dst, input logic reg_write,
                                          input logic mem_read);
    stage_tag_t t;
    t.valid     = 1'b1;
    t.dst       = dst;
    t.reg_write = reg_write;
    t.mem_read  = mem_read;
    return t;
  endfunction

endpackage

// File: rtl/pipe_haz_match.sv
// haz_match: compares one in-flight stage tag against one ID source register.
// match    - the stage will write the register the ID instruction reads.
// load_hit - same, and the producer is a load (data arrives late).
// Register 0 is hard-wired zero and never produces a match.
module haz_match
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  stage_tag_t            tag,
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  src_used,
  output logic                  match,
  output logic                  load_hit
);

  tag_reg_t src_ext;

  assign src_ext  = tag_reg_t'(src);
  assign match    = src_used && tag.valid && tag.reg_write &&
                    (src != '0) && (tag.dst == src_ext);
  assign load_hit = match && tag.mem_read;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard / forwarding controller for the pipelined CPU.
// Tracks a tag for every instruction in stages EX..NUM_TRK, and produces
// IF/ID stall, ID/EX bubble, branch flush (combinational) and the registered
// EX operand forward selects (0 = regfile, k = result of tracked stage k+1).
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter  int REG_ADDR_W = 5,
  parameter  int NUM_TRK    = 3,
  parameter  int LOAD_LAT   = 1,
  parameter  int RF_BYPASS  = 1,
  localparam int FWD_W      = $clog2(NUM_TRK)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_br_taken,
  input  logic                  ext_stall,
  output logic                  stall_if,
  output logic                  bubble_ex,
  output logic                  flush_id,
  output logic [FWD_W-1:0]      fwd_a_sel,
  output logic [FWD_W-1:0]      fwd_b_sel
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  // Stage masks over the tracked-stage vectors (bit s-1 = stage s).
  // LAT_MASK: stages whose load data is not yet usable by the instruction in ID.
  // FWD_MASK: stages that will sit in 2..NUM_TRK next cycle (forward sources).
  // WB_MASK : write-back stage, which stalls only without a write-through regfile.
  localparam logic [NUM_TRK:1] LAT_MASK = NUM_TRK'((1 << LOAD_LAT) - 1);
  localparam logic [NUM_TRK:1] FWD_MASK = NUM_TRK'((1 << (NUM_TRK - 1)) - 1);
  localparam logic [NUM_TRK:1] WB_MASK  = NUM_TRK'(1 << (WB_STAGE - 1));

  stage_tag_t       stage_tag [1:NUM_TRK];
  stage_tag_t       id_tag;
  logic             rs_used;
  logic             rt_used;
  logic [NUM_TRK:1] rs_hit;
  logic [NUM_TRK:1] rt_hit;
  logic [NUM_TRK:1] rs_ld;
  logic [NUM_TRK:1] rt_ld;
  logic [NUM_TRK:1] rs_fwd;
  logic [NUM_TRK:1] rt_fwd;
  logic             load_use;
  logic             wb_haz;
  logic             data_haz;
  logic [FWD_W-1:0] fwd_a_nxt;
  logic [FWD_W-1:0] fwd_b_nxt;

  assign rs_used = id_valid && id_use_rs;
  assign rt_used = id_valid && id_use_rt;
  assign id_tag  = make_tag(tag_reg_t'(id_dst), id_reg_write, id_mem_read);

  for (genvar s = 1; s <= NUM_TRK; s++) begin : g_match
    haz_match #(.REG_ADDR_W(REG_ADDR_W)) u_rs (
      .tag      (stage_tag[s]),
      .src      (id_rs),
      .src_used (rs_used),
      .match    (rs_hit[s]),
      .load_hit (rs_ld[s])
    );
    haz_match #(.REG_ADDR_W(REG_ADDR_W)) u_rt (
      .tag      (stage_tag[s]),
      .src      (id_rt),
      .src_used (rt_used),
      .match    (rt_hit[s]),
      .load_hit (rt_ld[s])
    );
  end

  assign load_use = |((rs_ld | rt_ld) & LAT_MASK);
  assign wb_haz   = (RF_BYPASS == 0) && (|((rs_hit | rt_hit) & WB_MASK));
  assign data_haz = load_use || wb_haz;

  // A load still inside its latency window cannot be a forward source.
  assign rs_fwd = rs_hit & ~(rs_ld & LAT_MASK) & FWD_MASK;
  assign rt_fwd = rt_hit & ~(rt_ld & LAT_MASK) & FWD_MASK;

  // Pipeline control: external stall freezes all, taken branch beats load-use.
  always_comb begin
    stall_if  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (ext_stall) begin
      stall_if = 1'b1;
    end else if (ex_br_taken) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (data_haz) begin
      stall_if  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  // Forward select for the ID instruction: youngest eligible producer wins.
  always_comb begin
    fwd_a_nxt = FWD_W'(FWD_REGFILE);
    fwd_b_nxt = FWD_W'(FWD_REGFILE);
    for (int j = NUM_TRK; j >= 1; j--) begin
      if (rs_fwd[j]) fwd_a_nxt = FWD_W'(j);
      if (rt_fwd[j]) fwd_b_nxt = FWD_W'(j);
    end
  end

  // ID -> EX boundary and EX..NUM_TRK tag shift; bubbles enter as invalid tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 1; s <= NUM_TRK; s++) stage_tag[s] <= TAG_INVALID;
    end else if (!ext_stall) begin
      stage_tag[1] <= (bubble_ex || !id_valid) ? TAG_INVALID : id_tag;
      for (int s = 2; s <= NUM_TRK; s++) stage_tag[s] <= stage_tag[s-1];
    end
  end

  // ID -> EX boundary for forward selects; a bubble reads the regfile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_sel <= FWD_W'(FWD_REGFILE);
      fwd_b_sel <= FWD_W'(FWD_REGFILE);
    end else if (!ext_stall) begin
      fwd_a_sel <= bubble_ex ? FWD_W'(FWD_REGFILE) : fwd_a_nxt;
      fwd_b_sel <= bubble_ex ? FWD_W'(FWD_REGFILE) : fwd_b_nxt;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Count data-hazard stall cycles (not memory waits) and branch flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_if && !ext_stall) stall_cnt <= sat_inc(stall_cnt);
      if (flush_id)               flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl. dut0 uses the default parameters
// (write-through regfile); dut1 is identical except RF_BYPASS=0. Both see
// the same stimulus. Counter checks are built when HAZ_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_use_rs = 1'b0;
  logic       id_use_rt = 1'b0;
  logic [4:0] id_dst = '0;
  logic       id_reg_write = 1'b0;
  logic       id_mem_read = 1'b0;
  logic       ex_br_taken = 1'b0;
  logic       ext_stall = 1'b0;

  logic       stall_if0, bubble_ex0, flush_id0;
  logic [1:0] fwd_a0, fwd_b0;
  logic       stall_if1, bubble_ex1, flush_id1;
  logic [1:0] fwd_a1, fwd_b1;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_br_taken(ex_br_taken), .ext_stall(ext_stall),
    .stall_if(stall_if0), .bubble_ex(bubble_ex0), .flush_id(flush_id0),
    .fwd_a_sel(fwd_a0), .fwd_b_sel(fwd_b0)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
`endif
  );

  pipe_hazard_ctrl #(.RF_BYPASS(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_br_taken(ex_br_taken), .ext_stall(ext_stall),
    .stall_if(stall_if1), .bubble_ex(bubble_ex1), .flush_id(flush_id1),
    .fwd_a_sel(fwd_a1), .fwd_b_sel(fwd_b1)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
  );

  // Present one instruction in ID.
  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dst = dst; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    @(negedge clk); nop(); ex_br_taken = 1'b0; ext_stall = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    @(negedge clk); @(negedge clk); #1;
    n_checks++;
    if ({stall_if0, bubble_ex0, flush_id0} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 000", {stall_if0, bubble_ex0, flush_id0});
    end
    n_checks++;
    if ({fwd_a0, fwd_b0, fwd_a1, fwd_b1} !== 8'h00) begin
      n_fail++; $display("FAIL reset_fwd: got %h expected 00", {fwd_a0, fwd_b0, fwd_a1, fwd_b1});
    end
    nop();
    rst_n = 1'b1;
  endtask

  // lw $2 ; add $3,$2,$4
  task automatic test_load_use();
    @(negedge clk); set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1); #1;
    n_checks++;
    if ({stall_if0, bubble_ex0, flush_id0} !== 3'b000) begin
      n_fail++; $display("FAIL lu_first: got %b expected 000", {stall_if0, bubble_ex0, flush_id0});
    end
    @(negedge clk); set_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0); #1;
    n_checks++;
    if ({stall_if0, bubble_ex0, flush_id0} !== 3'b110) begin
      n_fail++; $display("FAIL lu_stall: got %b expected 110", {stall_if0, bubble_ex0, flush_id0});
    end
    @(negedge clk); #1;
    n_checks++;
    if ({stall_if0, bubble_ex0, flush_id0} !== 3'b000) begin
      n_fail++; $display("FAIL lu_release: got %b expected 000", {stall_if0, bubble_ex0, flush_id0});
    end
    n_checks++;
    if (fwd_a0 !== 2'd0) begin
      n_fail++; $display("FAIL lu_bubble_fwd: got %0d expected 0", fwd_a0);
    end
    @(negedge clk); nop(); #1;
    n_checks++;
    if ({fwd_a0, fwd_b0} !== {2'd2, 2'd0}) begin
      n_fail++; $display("FAIL lu_fwd_wb: got a=%0d b=%0d expected a=2 b=0", fwd_a0, fwd_b0);
    end
  endtask

  // add $5,$8,$9 ; sub $6,$5,$5 ; and $7,$5,$6
  task automatic test_forward();
    @(negedge clk); set_id(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    @(negedge clk); set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); #1;
    n_checks++;
    if ({stall_if0, bubble_ex0, flush_id0} !== 3'b000) begin
      n_fail++; $display("FAIL fw_no_stall: got %b expected 000", {stall_if0, bubble_ex0, flush_id0});
    end
    @(negedge clk); set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0); #1;
    n_checks++;
    if ({fwd_a0, fwd_b0} !== {2'd1, 2'd1}) begin
      n_fail++; $display("FAIL fw_mem: got a=%0d b=%0d expected a=1 b=1", fwd_a0, fwd_b0);
    end
    @(negedge clk); nop(); #1;
    n_checks++;
    if ({fwd_a0, fwd_b0} !== {2'd2, 2'd1}) begin
      n_fail++; $display("FAIL fw_mixed: got a=%0d b=%0d expected a=2 b=1", fwd_a0, fwd_b0);
    end
  endtask

  // add $5 ; add $5,$5,$5 ; or $9,$5,$0 -> youngest producer of $5 wins
  task automatic test_back_to_back();
    @(negedge clk); set_id(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    @(negedge clk); set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    @(negedge clk); set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0); #1;
    n_checks++;
    if ({fwd_a0, fwd_b0} !== {2'd1, 2'd1}) begin
      n_fail++; $display("FAIL b2b_first: got a=%0d b=%0d expected a=1 b=1", fwd_a0, fwd_b0);
    end
    @(negedge clk); nop(); #1;
    n_checks++;
    if ({fwd_a0, fwd_b0} !== {2'd1, 2'd0}) begin
      n_fail++; $display("FAIL b2b_youngest: got a=%0d b=%0d expected a=1 b=0", fwd_a0, fwd_b0);
    end
  endtask

  // add $0 ; lw $0,0($0) ; or $7,$0,$0 -> register 0 never hazards or forwards
  task automatic test_zero_reg();
    @(negedge clk); set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    @(negedge clk); set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1); #1;
    n_checks++;
    if ({stall_if0, bubble_ex0, flush_id0} !== 3'b000) begin
      n_fail++; $display("FAIL z_stall1: got %b expected 000", {stall_if0, bubble_ex0, flush_id0});
    end
    @(negedge clk); set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0); #1;
    n_checks++;
    if ({stall_if0, bubble_ex0, flush_id0} !== 3'b000) begin
      n_fail++; $display("FAIL z_loaduse: got %b expected 000", {stall_if0, bubble_ex0, flush_id0});
    end
    @(negedge clk); nop(); #1;
    n_checks++;
    if ({fwd_a0, fwd_b0} !== {2'd0, 2'd0}) begin
      n_fail++; $display("FAIL z_fwd: got a=%0d b=%0d expected a=0 b=0", fwd_a0, fwd_b0);
    end
  endtask

  // lw $2 ; add $3,$2,$4 with a taken branch in EX the same cycle
  task automatic test_flush();
    @(negedge clk); set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
    @(negedge clk); set_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0); ex_br_taken = 1'b1; #1;
    n_checks++;
    if ({stall_if0, bubble_ex0, flush_id0} !== 3'b011) begin
      n_fail++; $display("FAIL fl_beats_lu: got %b expected 011", {stall_if0, bubble_ex0, flush_id0});
    end
    @(negedge clk); ex_br_taken = 1'b0; nop(); #1;
    n_checks++;
    if ({stall_if0, bubble_ex0, flush_id0, fwd_a0} !== 5'b00000) begin
      n_fail++; $display("FAIL fl_after: got %b expected 00000", {stall_if0, bubble_ex0, flush_id0, fwd_a0});
    end
  endtask

  // Forwarding stream frozen for 3 cycles by ext_stall (branch ignored meanwhile)
  task automatic test_ext_stall();
    @(negedge clk); set_id(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    @(negedge clk); set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    @(negedge clk); set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    ext_stall = 1'b1; ex_br_taken = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_checks++;
      if ({stall_if0, bubble_ex0, flush_id0, fwd_a0, fwd_b0} !== {3'b100, 2'd1, 2'd1}) begin
        n_fail++; $display("FAIL es_hold[%0d]: got ctl=%b a=%0d b=%0d expected ctl=100 a=1 b=1",
                           c, {stall_if0, bubble_ex0, flush_id0}, fwd_a0, fwd_b0);
      end
    end
    @(negedge clk); ext_stall = 1'b0; ex_br_taken = 1'b0; #1;
    n_checks++;
    if ({stall_if0, bubble_ex0, flush_id0, fwd_a0, fwd_b0} !== {3'b000, 2'd1, 2'd1}) begin
      n_fail++; $display("FAIL es_resume: got ctl=%b a=%0d b=%0d expected ctl=000 a=1 b=1",
                         {stall_if0, bubble_ex0, flush_id0}, fwd_a0, fwd_b0);
    end
    @(negedge clk); nop(); #1;
    n_checks++;
    if ({fwd_a0, fwd_b0} !== {2'd2, 2'd1}) begin
      n_fail++; $display("FAIL es_next_fwd: got a=%0d b=%0d expected a=2 b=1", fwd_a0, fwd_b0);
    end
  endtask

  // add $5 ; nop ; nop ; sub $6,$5,$1 -> only the non-write-through build stalls
  task automatic test_rf_bypass();
    @(negedge clk); rst_n = 1'b0; nop(); ex_br_taken = 1'b0; ext_stall = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    set_id(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    @(negedge clk); nop();
    @(negedge clk); nop();
    @(negedge clk); set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); #1;
    n_checks++;
    if ({stall_if1, bubble_ex1, flush_id1} !== 3'b110) begin
      n_fail++; $display("FAIL rf_stall: got %b expected 110", {stall_if1, bubble_ex1, flush_id1});
    end
    n_checks++;
    if ({stall_if0, bubble_ex0, flush_id0} !== 3'b000) begin
      n_fail++; $display("FAIL rf_writethrough: got %b expected 000", {stall_if0, bubble_ex0, flush_id0});
    end
    @(negedge clk); #1;
    n_checks++;
    if ({stall_if1, bubble_ex1, flush_id1} !== 3'b000) begin
      n_fail++; $display("FAIL rf_release: got %b expected 000", {stall_if1, bubble_ex1, flush_id1});
    end
    @(negedge clk); nop(); #1;
    n_checks++;
    if (fwd_a1 !== 2'd0) begin
      n_fail++; $display("FAIL rf_fwd: got %0d expected 0", fwd_a1);
    end
`ifdef HAZ_PERF_CNT_EN
    n_checks++;
    if ({stall_cnt1, flush_cnt1, stall_cnt0} !== {32'd1, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL cnt_stall: got s1=%0d f1=%0d s0=%0d expected 1 0 0",
                         stall_cnt1, flush_cnt1, stall_cnt0);
    end
    @(negedge clk); ex_br_taken = 1'b1;
    @(negedge clk); ex_br_taken = 1'b0; #1;
    n_checks++;
    if ({stall_cnt1, flush_cnt1} !== {32'd1, 32'd1}) begin
      n_fail++; $display("FAIL cnt_flush: got s1=%0d f1=%0d expected 1 1", stall_cnt1, flush_cnt1);
    end
`endif
  endtask

  // Async reset while a load-use stall and a forward select are live
  task automatic test_reset_mid();
    @(negedge clk); set_id(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    @(negedge clk); set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    @(negedge clk); set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    @(negedge clk); set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0); #1;
    n_checks++;
    if ({stall_if0, bubble_ex0, flush_id0, fwd_a0} !== {3'b110, 2'd2}) begin
      n_fail++; $display("FAIL rm_pre: got ctl=%b a=%0d expected ctl=110 a=2",
                         {stall_if0, bubble_ex0, flush_id0}, fwd_a0);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({stall_if0, bubble_ex0, flush_id0, fwd_a0} !== {3'b000, 2'd0}) begin
      n_fail++; $display("FAIL rm_async: got ctl=%b a=%0d expected ctl=000 a=0",
                         {stall_if0, bubble_ex0, flush_id0}, fwd_a0);
    end
`ifdef HAZ_PERF_CNT_EN
    n_checks++;
    if ({stall_cnt1, flush_cnt1} !== 64'd0) begin
      n_fail++; $display("FAIL rm_cnt: got s1=%0d f1=%0d expected 0 0", stall_cnt1, flush_cnt1);
    end
`endif
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++;
    if ({stall_if0, bubble_ex0, flush_id0} !== 3'b000) begin
      n_fail++; $display("FAIL rm_empty: got %b expected 000", {stall_if0, bubble_ex0, flush_id0});
    end
  endtask

  initial begin
    test_reset();
    test_load_use();      drain();
    test_forward();       drain();
    test_back_to_back();  drain();
    test_zero_reg();      drain();
    test_flush();         drain();
    test_ext_stall();     drain();
    test_rf_bypass();     drain();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
